epass_verify_arbiter: RTL and testbench
=======================================

Name: epass_verify_arbiter

Overview:
Shares the single Epass verification unit between NUM_LANES lane gate controllers. Each lane raises a request from its calculation phase and presents a tag. The arbiter grants one lane at a time in round-robin order, runs one start/done transaction with the verifier under a timeout watchdog, and returns a 2-bit verdict to the winning lane only. It sits between the per-lane controllers and the verifier.

Parameters:
NUM_LANES, 2, number of requesting lanes (2..4)
TAG_W, 8, vehicle tag width
TIMEOUT, 200, max cycles waiting for ver_done before forcing an error verdict (1..255)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
lane_req  in  NUM_LANES  level request per lane, held until its lane_rsp_vld
lane_tag  in  NUM_LANES*TAG_W  per-lane tag; lane i in bits [i*TAG_W +: TAG_W]
lane_grant  out  NUM_LANES  one-hot, registered; lane currently owning the verifier
lane_rsp_vld  out  NUM_LANES  one-cycle pulse to the granted lane when the verdict is valid
lane_rsp  out  2  verdict: 00 pending, 01 invalid/insufficient, 10 valid, 11 error
ver_start  out  1  one-cycle start pulse to the verifier
ver_tag  out  TAG_W  tag latched at grant; stable from ver_start until ver_done
ver_done  in  1  verifier completion pulse
ver_result  in  2  verifier verdict, sampled when ver_done=1
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset values: state=IDLE, lane_grant=0, lane_rsp_vld=0, lane_rsp=00, ver_start=0, ver_tag=0, timer=0, timeout_err=0.
- Reset sets rr_ptr to NUM_LANES-1, so lane 0 has first priority.
- Reset mid-transaction aborts immediately. No verdict is delivered. A late ver_done after reset is ignored in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if lane_req is non-zero, pick the first requesting lane at or after rr_ptr+1 (wrapping). Register its one-hot in lane_grant, latch its tag into ver_tag, go to ISSUE.
- ISSUE: ver_start=1 for exactly one cycle, clear timer, go to WAIT.
- WAIT:
  - If ver_done=1, capture ver_result into lane_rsp and go to RESP.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without ver_done: lane_rsp=11, timeout_err pulses, go to RESP.
  - ver_done and expiry in the same cycle: ver_done wins and no timeout_err is raised.
- RESP:
  - lane_rsp_vld[g]=1 for one cycle. lane_rsp holds its value until the next capture.
  - rr_ptr becomes g, lane_grant clears, go to IDLE.
  - Minimum spacing between grants is one IDLE cycle.
- Latency: request sampled in IDLE at edge k; grant visible after edge k; ver_start high in cycle k+1. With ver_done in cycle n, lane_rsp_vld is high in cycle n+1.
- Granted lane drops lane_req before RESP (car reversed out): the verifier transaction still completes, lane_rsp_vld is suppressed, and rr_ptr still advances.
- ver_done outside WAIT is ignored. ver_result is sampled only when ver_done=1.
- Non-granted requests wait; their tags are not sampled until grant.
- With every lane requesting continuously, grants rotate 0,1,..,NUM_LANES-1,0 with no starvation.

Optional Feature:
FIXED_PRIO_LANE0_EN:
- Defined: in IDLE, lane 0 (emergency/priority lane) wins whenever lane_req[0]=1. Remaining lanes round-robin among themselves, and rr_ptr is not updated by lane-0 grants.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package epass_arb_pkg holds:
  - verdict constants RSP_PENDING=2'b00, RSP_INVALID=2'b01, RSP_VALID=2'b10, RSP_ERROR=2'b11;
  - FSM state encoding, 2-bit;
  - default TIMEOUT.
- One natural sub-module, rr_picker: combinational; inputs req vector and ptr; output one-hot grant and any-valid flag. Instantiated once.

Test Plan:
- Single request: lane_req=01, ver_done 5 cycles after ver_start with ver_result=10 -> ver_tag=lane0 tag; lane_rsp_vld=01 for one cycle, lane_rsp=10; busy low the next cycle.
- Contention: lane_req=11 held, verifier answers 01 then 10 -> first grant lane 0 (lane_rsp=01), second grant lane 1 (lane_rsp=10), then lane 0 again.
- Timeout with TIMEOUT=200: no ver_done -> timeout_err pulses 200 cycles after ver_start; lane_rsp=11 to the granted lane; a later stray ver_done in IDLE has no effect.
- Simultaneous events: ver_done asserted on the exact expiry cycle -> verdict taken from ver_result, timeout_err stays 0.
- Request withdrawn: lane 1 drops lane_req during WAIT -> ver_done is consumed, lane_rsp_vld stays 00, next grant goes to lane 0.
- Async reset in WAIT -> all outputs 0 within the reset cycle. After release, lane_req=11 grants lane 0 first. With FIXED_PRIO_LANE0_EN and lane 0 requesting continuously, lane 0 is granted every transaction.

Source files
------------

// File: rtl/epass_arb_pkg.sv
// Shared constants for the Epass verifier arbiter: verdict codes, FSM encoding, defaults.
package epass_arb_pkg;

    localparam logic [1:0] RSP_PENDING = 2'b00;
    localparam logic [1:0] RSP_INVALID = 2'b01;
    localparam logic [1:0] RSP_VALID   = 2'b10;
    localparam logic [1:0] RSP_ERROR   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEFAULT_TIMEOUT = 200;

    // Pointer width for a lane index; never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/epass_verify_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (((int'(ptr) + off) % N) == i)) begin
                    gnt[i] = 1'b1;
                    any    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/epass_verify_arbiter.sv
// Shares one Epass verifier among NUM_LANES lanes: round-robin grant, start/done handshake, watchdog.
// Build option FIXED_PRIO_LANE0_EN: lane 0 wins whenever it requests and leaves rr_ptr untouched.
module epass_verify_arbiter
    import epass_arb_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int TAG_W     = 8,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_LANES-1:0]       lane_req,
    input  logic [NUM_LANES*TAG_W-1:0] lane_tag,
    output logic [NUM_LANES-1:0]       lane_grant,
    output logic [NUM_LANES-1:0]       lane_rsp_vld,
    output logic [1:0]                 lane_rsp,
    output logic                       ver_start,
    output logic [TAG_W-1:0]           ver_tag,
    input  logic                       ver_done,
    input  logic [1:0]                 ver_result,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int         PTR_W        = ptr_width(NUM_LANES);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]                        state;
    logic [PTR_W-1:0]                  rr_ptr;
    logic [7:0]                        timer;
    logic                              abandoned;
    logic [NUM_LANES-1:0][TAG_W-1:0]   tags;
    logic [NUM_LANES-1:0]              pick;
    logic                              pick_any;
    logic [NUM_LANES-1:0]              win;
    logic [TAG_W-1:0]                  win_tag;
    logic [PTR_W-1:0]                  grant_idx;
    logic                              owner_req;
    logic                              expire;

    assign tags = lane_tag;

    rr_picker #(.N(NUM_LANES), .PTR_W(PTR_W)) u_pick (
        .req (lane_req),
        .ptr (rr_ptr),
        .gnt (pick),
        .any (pick_any)
    );

    always_comb begin
        win = pick;
`ifdef FIXED_PRIO_LANE0_EN
        if (lane_req[0]) begin
            win    = '0;
            win[0] = 1'b1;
        end
`endif
    end

    always_comb begin
        win_tag   = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (win[i])        win_tag   = tags[i];
            if (lane_grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // A lane that lets go of its request mid-transaction forfeits the verdict pulse.
    assign owner_req = |(lane_req & lane_grant);

    // Expiry is decided in the same cycle as ver_done so a coincident done can win.
    assign expire      = (state == ST_WAIT) && !ver_done && (timer == TIMEOUT_LAST);
    assign timeout_err = expire;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= PTR_W'(NUM_LANES - 1);
            timer        <= '0;
            abandoned    <= 1'b0;
            lane_grant   <= '0;
            lane_rsp_vld <= '0;
            lane_rsp     <= RSP_PENDING;
            ver_start    <= 1'b0;
            ver_tag      <= '0;
        end else begin
            ver_start    <= 1'b0;
            lane_rsp_vld <= '0;
            if ((state == ST_ISSUE || state == ST_WAIT) && !owner_req)
                abandoned <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        lane_grant <= win;
                        ver_tag    <= win_tag;
                        ver_start  <= 1'b1;
                        abandoned  <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ver_done || expire) begin
                        lane_rsp     <= ver_done ? ver_result : RSP_ERROR;
                        lane_rsp_vld <= (abandoned || !owner_req) ? '0 : lane_grant;
                        state        <= ST_RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
`ifdef FIXED_PRIO_LANE0_EN
                    if (!lane_grant[0]) rr_ptr <= grant_idx;
`else
                    rr_ptr <= grant_idx;
`endif
                    lane_grant <= '0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epass_verify_arbiter.sv
// Directed bench for epass_verify_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_epass_verify_arbiter;
    localparam int NL = 2;
    localparam int TW = 8;
    localparam int TO = 200;
`ifdef FIXED_PRIO_LANE0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NL-1:0]    lane_req = '0;
    logic [NL*TW-1:0] lane_tag = {8'h3C, 8'hA5};
    logic [NL-1:0]    lane_grant, lane_rsp_vld;
    logic [1:0]       lane_rsp;
    logic             ver_start, busy, timeout_err;
    logic [TW-1:0]    ver_tag;
    logic             ver_done = 1'b0;
    logic [1:0]       ver_result = 2'b00;

    int n_cmp = 0;
    int n_err = 0;

    epass_verify_arbiter #(.NUM_LANES(NL), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .lane_req(lane_req), .lane_tag(lane_tag),
        .lane_grant(lane_grant), .lane_rsp_vld(lane_rsp_vld), .lane_rsp(lane_rsp),
        .ver_start(ver_start), .ver_tag(ver_tag), .ver_done(ver_done),
        .ver_result(ver_result), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit bitof(input logic [NL-1:0] v, input int i);
        return ((v >> i) & NL'(1)) != '0;
    endfunction

    function automatic int choose(input logic [NL-1:0] req, input int last);
        int r;
        r = -1;
        if (PRIO && req[0]) return 0;
        for (int off = 1; off <= NL; off++)
            if (r < 0 && bitof(req, (last + off) % NL)) r = (last + off) % NL;
        return r;
    endfunction

    // Model: owner lane, cycles since ver_start, whether the verdict is out this cycle.
    int            m_owner = -1;
    int            m_last  = NL - 1;
    int            m_t     = 0;
    bit            m_res   = 1'b0;
    bit            m_drop  = 1'b0;
    bit            m_del   = 1'b0;
    logic [1:0]    m_rsp   = 2'b00;
    logic [TW-1:0] m_tag   = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_last = NL - 1; m_t = 0;
            m_res = 1'b0; m_drop = 1'b0; m_del = 1'b0;
            m_rsp = 2'b00; m_tag = '0;
        end else if (m_owner < 0) begin
            m_owner = choose(lane_req, m_last);
            if (m_owner >= 0) begin
                m_tag = TW'(lane_tag >> (m_owner * TW));
                m_t = 0; m_res = 1'b0; m_drop = 1'b0; m_del = 1'b0;
            end
        end else if (m_res) begin
            if (!(PRIO && m_owner == 0)) m_last = m_owner;
            m_owner = -1; m_res = 1'b0; m_del = 1'b0;
        end else begin
            if (!bitof(lane_req, m_owner)) m_drop = 1'b1;
            if (m_t >= 1 && ver_done) begin
                m_rsp = ver_result; m_res = 1'b1;
            end else if (m_t == TO) begin
                m_rsp = 2'b11; m_res = 1'b1;
            end else begin
                m_t++;
            end
            m_del = m_res && !m_drop;
        end
    end

    logic [NL-1:0] e_grant, e_vld;
    logic          e_start, e_to;

    always @(negedge clk) begin
        e_grant = (m_owner >= 0) ? (NL'(1) << m_owner) : '0;
        e_vld   = (m_owner >= 0 && m_res && m_del) ? (NL'(1) << m_owner) : '0;
        e_start = (m_owner >= 0) && !m_res && (m_t == 0);
        e_to    = (m_owner >= 0) && !m_res && (m_t == TO) && !ver_done;
        chk("m_grant",   32'(lane_grant),   32'(e_grant));
        chk("m_rsp_vld", 32'(lane_rsp_vld), 32'(e_vld));
        chk("m_rsp",     32'(lane_rsp),     32'(m_rsp));
        chk("m_start",   32'(ver_start),    32'(e_start));
        chk("m_tag",     32'(ver_tag),      32'(m_tag));
        chk("m_busy",    32'(busy),         32'(m_owner >= 0));
        chk("m_timeout", 32'(timeout_err),  32'(e_to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (ver_start) found = 1'b1;
        end
        chk("start_seen", 32'(found), 32'd1);
    endtask

    task automatic run_txn(input logic [1:0] res, input int dly, input logic [NL-1:0] g, input string nm);
        wait_start();
        chk({nm, "_grant"}, 32'(lane_grant), 32'(g));
        repeat (dly) tick();
        ver_done = 1'b1; ver_result = res;
        tick();
        ver_done = 1'b0;
        chk({nm, "_vld"}, 32'(lane_rsp_vld), 32'(g));
        chk({nm, "_rsp"}, 32'(lane_rsp), 32'(res));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_grant"}, 32'(lane_grant), 32'd0);
        chk({nm, "_vld"},   32'(lane_rsp_vld), 32'd0);
        chk({nm, "_rsp"},   32'(lane_rsp), 32'd0);
        chk({nm, "_start"}, 32'(ver_start), 32'd0);
        chk({nm, "_tag"},   32'(ver_tag), 32'd0);
        chk({nm, "_busy"},  32'(busy), 32'd0);
        chk({nm, "_to"},    32'(timeout_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [NL-1:0] eg;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        tick();

        // Single request, done 5 cycles after start.
        lane_req = 2'b01;
        wait_start();
        chk("single_tag", 32'(ver_tag), 32'h A5);
        chk("single_grant", 32'(lane_grant), 32'h1);
        repeat (5) tick();
        ver_done = 1'b1; ver_result = 2'b10;
        tick();
        ver_done = 1'b0;
        chk("single_vld", 32'(lane_rsp_vld), 32'h1);
        chk("single_rsp", 32'(lane_rsp), 32'h2);
        lane_req = 2'b00;
        tick();
        chk("single_busy_low", 32'(busy), 32'd0);
        chk("single_vld_pulse", 32'(lane_rsp_vld), 32'd0);

        // Reset restores lane-0-first priority; contention rotates.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        lane_req = 2'b11;
        run_txn(2'b01, 3, 2'b01, "cont0");
        run_txn(2'b10, 3, 2'b10, "cont1");
        run_txn(2'b10, 2, 2'b01, "cont2");

        // Timeout: no ver_done.
        lane_req = 2'b01;
        wait_start();
        chk("to_tag", 32'(ver_tag), 32'h A5);
        cnt = 0;
        for (int i = 0; i < 300 && !timeout_err; i++) begin
            tick();
            cnt++;
        end
        chk("to_cycles", 32'(cnt), 32'd200);
        tick();
        chk("to_rsp", 32'(lane_rsp), 32'h3);
        chk("to_vld", 32'(lane_rsp_vld), 32'h1);
        chk("to_pulse", 32'(timeout_err), 32'd0);
        lane_req = 2'b00;
        tick();
        ver_done = 1'b1; ver_result = 2'b10;
        tick();
        ver_done = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_rsp", 32'(lane_rsp), 32'h3);
        chk("stray_vld", 32'(lane_rsp_vld), 32'd0);

        // ver_done on the exact expiry cycle.
        lane_req = 2'b10;
        wait_start();
        chk("sim_tag", 32'(ver_tag), 32'h3C);
        repeat (200) tick();
        ver_done = 1'b1; ver_result = 2'b01;
        #1;
        chk("sim_no_to", 32'(timeout_err), 32'd0);
        tick();
        ver_done = 1'b0;
        chk("sim_rsp", 32'(lane_rsp), 32'h1);
        chk("sim_vld", 32'(lane_rsp_vld), 32'h2);
        lane_req = 2'b00;

        // Lane 1 withdraws during WAIT.
        lane_req = 2'b10;
        wait_start();
        repeat (2) tick();
        lane_req = 2'b00;
        repeat (2) tick();
        ver_done = 1'b1; ver_result = 2'b10;
        tick();
        ver_done = 1'b0;
        chk("drop_vld", 32'(lane_rsp_vld), 32'd0);
        chk("drop_rsp", 32'(lane_rsp), 32'h2);
        chk("drop_busy", 32'(busy), 32'd1);
        lane_req = 2'b11;
        run_txn(2'b01, 2, 2'b01, "after_drop");

        // Asynchronous reset while waiting on the verifier.
        wait_start();
        chk("ar_grant", 32'(lane_grant), 32'h2);
        repeat (3) tick();
        chk("ar_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        lane_req = 2'b00;
        repeat (2) tick();
        reset_n = 1'b1;
        ver_done = 1'b1; ver_result = 2'b11;
        tick();
        ver_done = 1'b0;
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_rsp", 32'(lane_rsp), 32'd0);
        lane_req = 2'b11;
        run_txn(2'b10, 2, 2'b01, "post_rst");

        // Continuous requests: rotation, or lane 0 every time with the priority build.
        for (int k = 0; k < 3; k++) begin
            eg = PRIO ? 2'b01 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            run_txn(2'(k + 1), 1 + k, eg, "rot");
        end
        lane_req = 2'b00;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
